melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter BEAT_DIV, default 10_000_000, clock cycles per beat; legal range is 4 or more.
REQ-002 Parameter GAP_CYC, default 400_000, rest cycles at the end of each note; legal range is 1 to BEAT_DIV-1.
REQ-003 Parameter REST_CODE, default 4'd0, value code meaning silence.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  one-cycle play request.
REQ-007 stop  input  1  one-cycle abort request.
REQ-008 loop  input  1  level; 1 = repeat song at end-of-song.
REQ-009 value  output  4  note code to the downstream note-divider lookup.
REQ-010 playing  output  1  high while in state NOTE.
REQ-011 note_strobe  output  1  high on the first cycle of each note.
REQ-012 note_idx  output  4  current song ROM index.
REQ-013 done  output  1  one-cycle pulse when the song ends with loop=0.

Function
REQ-014 The song ROM SHALL have 16 entries of {dur[2:0], note[3:0]}; dur=0 marks end-of-song.
REQ-015 ROM contents (note,dur) for indices 0..13 SHALL be (1,1)(1,1)(5,1)(5,1)(6,1)(6,1)(5,2)(4,1)(4,1)(3,1)(3,1)(2,1)(2,1)(1,2); indices 14 and 15 SHALL have dur=0.
REQ-016 The FSM SHALL have exactly two states: IDLE and NOTE.
REQ-017 IDLE with start=1 and stop=0: next cycle NOTE, note_idx=0, beat prescaler=0, beat count=0.
REQ-018 start in NOTE SHALL be ignored.
REQ-019 stop=1 in any state: next cycle IDLE; stop wins over a simultaneous start or end-of-note.
REQ-020 A note of duration d SHALL occupy exactly d*BEAT_DIV cycles in NOTE, counted by a 0..BEAT_DIV-1 prescaler and a 3-bit beat counter.
REQ-021 value SHALL equal the ROM note, except in the last GAP_CYC cycles of a note's final beat (prescaler >= BEAT_DIV-GAP_CYC), where it SHALL equal REST_CODE.
REQ-022 value SHALL equal REST_CODE whenever the state is IDLE.
REQ-023 On a note's last cycle, the sequencer SHALL advance to note_idx+1 with no extra cycle.
REQ-024 If the next entry has dur=0, or note_idx=15 wraps to 0, the transition SHALL be treated as end-of-song.
REQ-025 No cycle SHALL be spent on the end marker.
REQ-026 End-of-song with loop=1, sampled on the last cycle: next cycle SHALL be NOTE, note_idx=0, note_strobe=1.
REQ-027 End-of-song with loop=0: next cycle SHALL be IDLE, and done SHALL be 1 for exactly that one cycle.
REQ-028 done SHALL be 0 after a stop.
REQ-029 note_strobe SHALL be 1 on the first NOTE cycle of every note, including index 0 after start or loop, and 0 otherwise.
REQ-030 playing SHALL be 1 exactly when state=NOTE.
REQ-031 note_idx SHALL hold its last value in IDLE and reset to 0 on each start.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, note_idx=0, value=REST_CODE, playing=0, note_strobe=0, done=0, and all counters to 0.
REQ-034 Reset SHALL take effect mid-note, and no output pulse SHALL be emitted.
REQ-035 start SHALL be ignored while rst_n=0.

Verification (BEAT_DIV=8, GAP_CYC=2)
REQ-036 Reset: hold rst_n=0 for 3 cycles -> value=0, playing=0, note_idx=0, done=0.
REQ-037 Start pulse at cycle T:
- T+1: playing=1, note_strobe=1, note_idx=0, value=1.
- T+1..T+6: value=1; T+7..T+8: value=0.
- T+9: note_idx=1, note_strobe=1, value=1.
REQ-038 Two-beat note at index 6: value=5 for 14 cycles, then 0 for 2 cycles, then note_idx=7, value=4.
REQ-039 Song end, loop=0: 128 NOTE cycles after start; next cycle done=1, playing=0, value=0, note_idx holds 13.
REQ-040 Song end, loop=1: after the 128th NOTE cycle -> note_idx=0, note_strobe=1, value=1, done=0.
REQ-041 Abort and reset cases:
- stop mid-note at index 3 -> next cycle IDLE, value=0, done=0.
- start and stop in the same cycle while IDLE -> remains IDLE.
- rst_n=0 mid-note -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// Control and output bundle of the melody sequencer.
// The player side drives start/stop/loop; the sequencer drives the note outputs.
interface melody_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] value;
  logic       playing;
  logic       note_strobe;
  logic [3:0] note_idx;
  logic       done;

  modport master (
    output start, stop, loop,
    input  value, playing, note_strobe, note_idx, done
  );

  modport slave (
    input  start, stop, loop,
    output value, playing, note_strobe, note_idx, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a fixed 16-entry song ROM, one note per d*BEAT_DIV cycles, with a
// short rest at the tail of each note; every output comes straight from a flop.
module melody_sequencer #(
  parameter int unsigned BEAT_DIV  = 10_000_000,
  parameter int unsigned GAP_CYC   = 400_000,
  parameter logic [3:0]  REST_CODE = 4'd0
) (
  input logic             clk,
  input logic             rst_n,
  melody_sequencer_if.slave bus
);

  localparam int unsigned     PW        = $clog2(BEAT_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(BEAT_DIV - 1);
  localparam logic [PW-1:0]   GAP_START = PW'(BEAT_DIV - GAP_CYC);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_NOTE = 1'b1} state_t;

  // Song entry: {dur[2:0], note[3:0]}; dur=0 terminates the song.
  function automatic logic [6:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_word = {3'd1, 4'd1};
      4'd1:    rom_word = {3'd1, 4'd1};
      4'd2:    rom_word = {3'd1, 4'd5};
      4'd3:    rom_word = {3'd1, 4'd5};
      4'd4:    rom_word = {3'd1, 4'd6};
      4'd5:    rom_word = {3'd1, 4'd6};
      4'd6:    rom_word = {3'd2, 4'd5};
      4'd7:    rom_word = {3'd1, 4'd4};
      4'd8:    rom_word = {3'd1, 4'd4};
      4'd9:    rom_word = {3'd1, 4'd3};
      4'd10:   rom_word = {3'd1, 4'd3};
      4'd11:   rom_word = {3'd1, 4'd2};
      4'd12:   rom_word = {3'd1, 4'd2};
      4'd13:   rom_word = {3'd2, 4'd1};
      default: rom_word = 7'd0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    beat_q, beat_d;
  logic [3:0]    value_q, value_d;
  logic          playing_q, strobe_q, strobe_d, done_q, done_d;

  logic [2:0]    cur_dur_s, nxt_dur_s;
  logic [3:0]    next_idx_s;
  logic          last_cycle_s, song_end_s;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    presc_d      = presc_q;
    beat_d       = beat_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    cur_dur_s    = rom_word(idx_q)[6:4];
    next_idx_s   = idx_q + 4'd1;
    last_cycle_s = (presc_q == PRESC_MAX) && (beat_q == (cur_dur_s - 3'd1));
    song_end_s   = (idx_q == 4'd15) || (rom_word(next_idx_s)[6:4] == 3'd0);

    if (bus.stop) begin
      state_d = ST_IDLE;
      presc_d = '0;
      beat_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d  = ST_NOTE;
            idx_d    = 4'd0;
            presc_d  = '0;
            beat_d   = 3'd0;
            strobe_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_NOTE: begin
          if (last_cycle_s) begin
            presc_d = '0;
            beat_d  = 3'd0;
            if (!song_end_s) begin
              idx_d    = next_idx_s;
              strobe_d = 1'b1;
            end else if (bus.loop) begin
              idx_d    = 4'd0;
              strobe_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            beat_d  = beat_q + 3'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          beat_d  = 3'd0;
        end
      endcase
    end

    // Output value is looked ahead from the next state so it can be registered.
    nxt_dur_s = rom_word(idx_d)[6:4];
    if ((state_d == ST_NOTE) &&
        !((beat_d == (nxt_dur_s - 3'd1)) && (presc_d >= GAP_START))) begin
      value_d = rom_word(idx_d)[3:0];
    end else begin
      value_d = REST_CODE;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      presc_q   <= '0;
      beat_q    <= 3'd0;
      value_q   <= REST_CODE;
      playing_q <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      beat_q    <= beat_d;
      value_q   <= value_d;
      playing_q <= (state_d == ST_NOTE);
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.playing     = playing_q;
  assign bus.note_strobe = strobe_q;
  assign bus.note_idx    = idx_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with BEAT_DIV=8, GAP_CYC=2: stimulus queues
// hand-computed expected outputs per cycle, a negedge monitor pops and compares them.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] value;
    logic       playing;
    logic       strobe;
    logic [3:0] idx;
    logic       done;
  } exp_t;

  exp_t q[$];

  melody_sequencer_if bus_if ();

  melody_sequencer #(.BEAT_DIV(8), .GAP_CYC(2), .REST_CODE(4'd0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string n, input int v, input int p,
                      input int s, input int i, input int d);
    exp_t e;
    e.cyc = c; e.name = n; e.value = 4'(v); e.playing = 1'(p);
    e.strobe = 1'(s); e.idx = 4'(i); e.done = 1'(d);
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cyc %0d not compared in time (now %0d)", e.name, e.cyc, cyc);
      end else if (bus_if.value !== e.value || bus_if.playing !== e.playing ||
                   bus_if.note_strobe !== e.strobe || bus_if.note_idx !== e.idx ||
                   bus_if.done !== e.done) begin
        errors++;
        $display("FAIL %s @cyc %0d: got value=%0d playing=%0d strobe=%0d idx=%0d done=%0d, want value=%0d playing=%0d strobe=%0d idx=%0d done=%0d",
                 e.name, cyc, bus_if.value, bus_if.playing, bus_if.note_strobe, bus_if.note_idx,
                 bus_if.done, e.value, e.playing, e.strobe, e.idx, e.done);
      end
    end
  end

  initial begin
    int t0, t1, t2, c;
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    bus_if.loop  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    push(cyc + 1, "reset_release", 0, 0, 0, 0, 0);
    push(cyc + 2, "idle", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full song, loop=0, with a start pulse mid-song that must be ignored.
    t0 = cyc + 1;
    bus_if.start = 1'b1;
    push(t0,       "first_note",    1, 1, 1, 0, 0);
    push(t0 + 5,   "note0_tone",    1, 1, 0, 0, 0);
    push(t0 + 6,   "note0_gap",     0, 1, 0, 0, 0);
    push(t0 + 7,   "note0_gap_end", 0, 1, 0, 0, 0);
    push(t0 + 8,   "note1_start",   1, 1, 1, 1, 0);
    push(t0 + 48,  "note6_start",   5, 1, 1, 6, 0);
    push(t0 + 61,  "note6_tone",    5, 1, 0, 6, 0);
    push(t0 + 62,  "note6_gap",     0, 1, 0, 6, 0);
    push(t0 + 63,  "note6_gap_end", 0, 1, 0, 6, 0);
    push(t0 + 64,  "note7_start",   4, 1, 1, 7, 0);
    push(t0 + 112, "note13_start",  1, 1, 1, 13, 0);
    push(t0 + 127, "song_last",     0, 1, 0, 13, 0);
    push(t0 + 128, "song_done",     0, 0, 0, 13, 1);
    push(t0 + 129, "done_cleared",  0, 0, 0, 13, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_to(t0 + 19);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_to(t0 + 132);

    // Looping song, then stop in the middle of index 3 of the second pass.
    bus_if.loop = 1'b1;
    t1 = cyc + 1;
    bus_if.start = 1'b1;
    push(t1,       "loop_first",   1, 1, 1, 0, 0);
    push(t1 + 127, "loop_last",    0, 1, 0, 13, 0);
    push(t1 + 128, "loop_wrap",    1, 1, 1, 0, 0);
    push(t1 + 129, "loop_wrap2",   1, 1, 0, 0, 0);
    push(t1 + 154, "before_stop",  5, 1, 0, 3, 0);
    push(t1 + 155, "after_stop",   0, 0, 0, 3, 0);
    push(t1 + 156, "stop_idle",    0, 0, 0, 3, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_to(t1 + 154);
    bus_if.stop = 1'b1;
    @(negedge clk);
    bus_if.stop = 1'b0;
    bus_if.loop = 1'b0;
    repeat (3) @(negedge clk);

    // Start and stop together while idle.
    c = cyc + 1;
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    push(c,     "start_stop",   0, 0, 0, 3, 0);
    push(c + 1, "start_stop_2", 0, 0, 0, 3, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-note, with start held during reset.
    t2 = cyc + 1;
    bus_if.start = 1'b1;
    push(t2,      "restart",      1, 1, 1, 0, 0);
    push(t2 + 9,  "pre_reset",    1, 1, 0, 1, 0);
    push(t2 + 10, "mid_reset",    0, 0, 0, 0, 0);
    push(t2 + 11, "reset_start",  0, 0, 0, 0, 0);
    push(t2 + 12, "post_reset",   0, 0, 0, 0, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_to(t2 + 9);
    rst_n = 1'b0;
    bus_if.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.start = 1'b0;

    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for cyc %0d (now %0d)", e.name, e.cyc, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
